// File: rtl/stack_eval_ctrl.sv
// Stack-machine sequencer: fetches ops from instruction memory and drives an operand
// stack and a local frame, with a bit-serial restoring divider for DIV.
module stack_eval_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ARG_W   = 16,
    parameter int PC_W    = 10,
    parameter int DEPTH   = 16,
    parameter int NLOCALS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [ARG_W+3:0]  imem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [DATA_W-1:0] result
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int SA_W  = $clog2(DEPTH);
    localparam int LA_W  = $clog2(NLOCALS);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DIV, S_DONE, S_ERR} state_t;
    typedef enum logic [3:0] {
        OP_PUSH, OP_LOAD, OP_STORE, OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
        OP_EQ, OP_NE, OP_GT, OP_GE, OP_JZ, OP_JMP, OP_RET, OP_ILL
    } op_t;
    typedef enum logic [2:0] {E_NONE, E_OVF, E_UNF, E_DIVZ, E_ILL} err_t;

    state_t            state_q, state_d;
    err_t              err_q, err_d, fault;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] stk_q [DEPTH];
    logic [DATA_W-1:0] loc_q [NLOCALS];

    // Divider: rem/quo shift together, quo starts as the dividend magnitude.
    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   shifted, trial;

    op_t               op;
    logic [ARG_W-1:0]  arg;
    logic [DATA_W-1:0] top, nos, alu;
    logic [1:0]        need;
    logic              grows, bad, slot_bad;
    logic              stk_we, loc_we, loc_clr;
    logic [SA_W-1:0]   stk_wa;
    logic [DATA_W-1:0] stk_wd;

    assign op       = op_t'(imem_rdata[ARG_W+3:ARG_W]);
    assign arg      = imem_rdata[ARG_W-1:0];
    assign top      = stk_q[SA_W'(sp_q - SP_W'(1))];
    assign nos      = stk_q[SA_W'(sp_q - SP_W'(2))];
    assign slot_bad = (32'(arg) >= NLOCALS);

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        need  = 2'd0;
        grows = 1'b0;
        bad   = 1'b0;
        alu   = '0;
        case (op)
            OP_PUSH:                begin grows = 1'b1; end
            OP_LOAD:                begin grows = 1'b1; bad = slot_bad; end
            OP_STORE:               begin need = 2'd1;  bad = slot_bad; end
            OP_POP, OP_JZ, OP_RET:  begin need = 2'd1; end
            OP_JMP:                 begin need = 2'd0; end
            OP_ILL:                 begin bad = 1'b1; end
            default:                begin need = 2'd2; end
        endcase
        case (op)
            OP_ADD:  alu = nos + top;
            OP_SUB:  alu = nos - top;
            OP_MUL:  alu = nos * top;
            OP_EQ:   alu = DATA_W'(nos == top);
            OP_NE:   alu = DATA_W'(nos != top);
            OP_GT:   alu = DATA_W'($signed(nos) >  $signed(top));
            OP_GE:   alu = DATA_W'($signed(nos) >= $signed(top));
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        result_d = result_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        fault    = E_NONE;
        imem_en  = 1'b0;
        stk_we   = 1'b0;
        stk_wa   = SA_W'(sp_q);
        stk_wd   = '0;
        loc_we   = 1'b0;
        loc_clr  = 1'b0;
        shifted  = {rem_q, quo_q[DATA_W-1]};
        trial    = shifted - {1'b0, dvs_q};
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    sp_d     = '0;
                    result_d = '0;
                    err_d    = E_NONE;
                    loc_clr  = 1'b1;
                end
            end
            S_FETCH: begin
                imem_en = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bad)                                         fault = E_ILL;
                else if (SP_W'(need) > sp_q)                     fault = E_UNF;
                else if (grows && sp_q == SP_W'(DEPTH))          fault = E_OVF;
                else if (op == OP_DIV && top == '0)              fault = E_DIVZ;
                state_d = S_FETCH;
                pc_d    = pc_q + PC_W'(1);
                if (fault != E_NONE) begin
                    state_d = S_ERR;
                    err_d   = fault;
                    pc_d    = pc_q;
                end else begin
                    case (op)
                        OP_PUSH: begin
                            stk_we = 1'b1;
                            stk_wd = {{(DATA_W-ARG_W){arg[ARG_W-1]}}, arg};
                            sp_d   = sp_q + SP_W'(1);
                        end
                        OP_LOAD: begin
                            stk_we = 1'b1;
                            stk_wd = loc_q[LA_W'(arg)];
                            sp_d   = sp_q + SP_W'(1);
                        end
                        OP_STORE: loc_we = 1'b1;
                        OP_POP:   sp_d = sp_q - SP_W'(1);
                        OP_DIV: begin
                            state_d = S_DIV;
                            pc_d    = pc_q;
                            neg_d   = nos[DATA_W-1] ^ top[DATA_W-1];
                            quo_d   = nos[DATA_W-1] ? -nos : nos;
                            dvs_d   = top[DATA_W-1] ? -top : top;
                            rem_d   = '0;
                            cnt_d   = '0;
                        end
                        OP_JZ: begin
                            sp_d = sp_q - SP_W'(1);
                            if (top == '0) pc_d = arg[PC_W-1:0];
                        end
                        OP_JMP: pc_d = arg[PC_W-1:0];
                        OP_RET: begin
                            state_d  = S_DONE;
                            pc_d     = pc_q;
                            result_d = top;
                            sp_d     = sp_q - SP_W'(1);
                        end
                        default: begin
                            stk_we = 1'b1;
                            stk_wa = SA_W'(sp_q - SP_W'(2));
                            stk_wd = alu;
                            sp_d   = sp_q - SP_W'(1);
                        end
                    endcase
                end
            end
            S_DIV: begin
                rem_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                cnt_d = cnt_q + CNT_W'(1);
                // Operands stay on the stack until the last quotient bit lands.
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    stk_we  = 1'b1;
                    stk_wa  = SA_W'(sp_q - SP_W'(2));
                    stk_wd  = neg_q ? -quo_d : quo_d;
                    sp_d    = sp_q - SP_W'(1);
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            err_q    <= E_NONE;
            pc_q     <= '0;
            sp_q     <= '0;
            result_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < NLOCALS; i++) loc_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            if (loc_clr) begin
                for (int i = 0; i < NLOCALS; i++) loc_q[i] <= '0;
            end else if (loc_we) begin
                loc_q[LA_W'(arg)] <= top;
            end
        end
    end

    // NOTE: stack entries are not reset; sp==0 marks them all invalid, so a reset
    // mux on the array would be pure cost.
    always_ff @(posedge clk) begin
        if (stk_we) stk_q[stk_wa] <= stk_wd;
    end

    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_DIV);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign err_code  = err_q;
    assign result    = result_q;
    assign imem_addr = pc_q;
endmodule

// File: tb/tb_stack_eval_ctrl.sv
// Bench for stack_eval_ctrl: an instruction-level interpreter predicts the per-cycle
// outputs of directed and random programs; a compare process checks every cycle.
module tb_stack_eval_ctrl;
    localparam int DW = 32, AW = 16, PW = 10, DEPTH = 16, NL = 16, IW = AW + 4;
    localparam int MAXC = 8192;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          imem_en, busy, done, error;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic [2:0]    err_code;
    logic [DW-1:0] result;

    stack_eval_ctrl #(.DATA_W(DW), .ARG_W(AW), .PC_W(PW), .DEPTH(DEPTH), .NLOCALS(NL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .result(result)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom [1024];
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

    typedef struct packed {
        logic          busy, done, error;
        logic [2:0]    err;
        logic [DW-1:0] res;
        logic          en;
        logic [PW-1:0] addr;
    } obs_t;

    obs_t trace [MAXC];
    int   t_len;
    int   checks = 0, failures = 0;
    int   cyc = 0;
    bit   cmp_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] ins(input int op, input int arg);
        return {op[3:0], arg[AW-1:0]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = ins(14, 0);
    endtask

    // Instruction-level interpreter; records the observable outputs expected after
    // each clock edge following the one that samples start.
    task automatic model_run();
        logic [DW-1:0]        st [$];
        logic [DW-1:0]        loc [NL];
        logic signed [DW-1:0] l, r, v;
        logic [IW-1:0]        w;
        logic [3:0]           op;
        logic [AW-1:0]        arg;
        logic [2:0]           e;
        int                   pc, pc_next, k, need;
        bit                   grows, bad, fin;
        obs_t                 b;
        for (int i = 0; i < NL; i++) loc[i] = '0;
        b = '0;
        b.busy = 1'b1;
        pc = 0; k = 0; fin = 1'b0;
        for (int step = 0; step < 4000 && !fin && k < MAXC - 40; step++) begin
            w = rom[pc]; op = w[IW-1:AW]; arg = w[AW-1:0];
            trace[k] = b; trace[k].en = 1'b1; trace[k].addr = pc[PW-1:0];
            trace[k+1] = b;
            k += 2;
            need  = (op >= 4 && op <= 11) ? 2 : (op == 2 || op == 3 || op == 12 || op == 14) ? 1 : 0;
            grows = (op == 0 || op == 1);
            bad   = (op == 15) || ((op == 1 || op == 2) && int'(arg) >= NL);
            e = 3'd0;
            if (bad)                                   e = 3'd4;
            else if (need > st.size())                 e = 3'd2;
            else if (grows && st.size() == DEPTH)      e = 3'd1;
            else if (op == 7 && st[$] == '0)           e = 3'd3;
            if (e != 3'd0) begin
                trace[k] = '0; trace[k].error = 1'b1; trace[k].err = e;
                fin = 1'b1;
            end else begin
                pc_next = pc + 1;
                case (op)
                    4'd0: st.push_back({{(DW-AW){arg[AW-1]}}, arg});
                    4'd1: st.push_back(loc[arg]);
                    4'd2: loc[arg] = st[$];
                    4'd3: void'(st.pop_back());
                    4'd12: begin
                        v = st.pop_back();
                        if (v == 0) pc_next = int'(arg);
                    end
                    4'd13: pc_next = int'(arg);
                    4'd14: begin
                        trace[k] = '0; trace[k].done = 1'b1; trace[k].res = st.pop_back();
                        fin = 1'b1;
                    end
                    default: begin
                        r = st.pop_back();
                        l = st.pop_back();
                        case (op)
                            4'd4: v = l + r;
                            4'd5: v = l - r;
                            4'd6: v = l * r;
                            4'd7: v = (l == 32'sh8000_0000 && r == -1) ? l : l / r;
                            4'd8: v = (l == r) ? 1 : 0;
                            4'd9: v = (l != r) ? 1 : 0;
                            4'd10: v = (l > r) ? 1 : 0;
                            default: v = (l >= r) ? 1 : 0;
                        endcase
                        st.push_back(v);
                        if (op == 7) begin
                            for (int i = 0; i < DW; i++) trace[k+i] = b;
                            k += DW;
                        end
                    end
                endcase
                pc = pc_next % 1024;
            end
        end
        t_len = k;
        if (!fin) begin
            trace[k] = '0;
            check("model_terminates", 64'(fin), 64'd1);
        end
    endtask

    // Single compare process: DUT outputs against the model trace, every cycle.
    always @(negedge clk) begin
        if (cmp_on) begin
            automatic int   idx = (cyc > t_len) ? t_len : cyc;
            automatic obs_t act;
            act.busy  = busy;
            act.done  = done;
            act.error = error;
            act.err   = err_code;
            act.res   = result;
            act.en    = imem_en;
            act.addr  = trace[idx].en ? imem_addr : '0;
            check($sformatf("cycle%0d", cyc), 64'(act), 64'(trace[idx]));
            cyc++;
        end
    end

    // Runs the ROM program; mid>=0 pulses start again while the program is busy.
    task automatic run_prog(input int mid, input int stop_after);
        model_run();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; cmp_on = 1'b1;
        for (int i = 0; i < t_len + 3 && i < stop_after; i++) begin
            @(negedge clk); #1;
            start = (i == mid);
        end
        start = 1'b0;
        cmp_on = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check(name, {busy, done, error, err_code, imem_en, imem_addr, result}, 64'd0);
    endtask

    task automatic load_t1();
        clear_rom();
        rom[0] = ins(0, 2); rom[1] = ins(0, 3); rom[2] = ins(6, 0);
        rom[3] = ins(0, 4); rom[4] = ins(4, 0); rom[5] = ins(14, 0);
    endtask

    task automatic load_div(input int a, input int b);
        clear_rom();
        rom[0] = ins(0, a); rom[1] = ins(0, b); rom[2] = ins(7, 0); rom[3] = ins(14, 0);
    endtask

    initial begin
        int len, rnd, tgt;
        clear_rom();
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst_n = 1'b1;

        load_t1();
        run_prog(-1, MAXC);
        check("t1_result", 64'(result), 64'd10);
        check("t1_errcode", 64'({done, err_code}), 64'h8);
        check("t1_latency", 64'(t_len), 64'd12);

        load_t1();
        run_prog(5, MAXC);
        check("restart_ignored", 64'(result), 64'd10);

        clear_rom();
        rom[0] = ins(0, 0);  rom[1] = ins(2, 0);  rom[2] = ins(3, 0);  rom[3] = ins(0, 5);
        rom[4] = ins(1, 0);  rom[5] = ins(10, 0); rom[6] = ins(12, 13); rom[7] = ins(1, 0);
        rom[8] = ins(0, 1);  rom[9] = ins(4, 0);  rom[10] = ins(2, 0); rom[11] = ins(3, 0);
        rom[12] = ins(13, 3); rom[13] = ins(1, 0); rom[14] = ins(14, 0);
        run_prog(-1, MAXC);
        check("loop_result", 64'(result), 64'd5);

        load_div(-7, 2);
        run_prog(-1, MAXC);
        check("div_result", 64'(result), 64'(32'hFFFF_FFFD));
        check("div_cycles", 64'(t_len), 64'd40);

        load_div(7, 0);
        run_prog(-1, MAXC);
        check("divz_code", 64'({error, busy, err_code}), 64'b1_0_011);
        check("divz_cycles", 64'(t_len), 64'd6);

        clear_rom();
        rom[0] = ins(0, -32768); rom[1] = ins(0, 16384); rom[2] = ins(6, 0);
        rom[3] = ins(0, 4);      rom[4] = ins(6, 0);     rom[5] = ins(0, -1);
        rom[6] = ins(7, 0);      rom[7] = ins(14, 0);
        run_prog(-1, MAXC);
        check("intmin_div", 64'(result), 64'(32'h8000_0000));

        clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = ins(0, i + 1);
        run_prog(-1, MAXC);
        check("full_legal", 64'({done, result}), {31'd0, 1'b1, 32'd16});

        rom[DEPTH] = ins(0, 99);
        run_prog(-1, MAXC);
        check("overflow", 64'({error, err_code}), 64'b1_001);

        rom[DEPTH] = ins(1, 20);
        run_prog(-1, MAXC);
        check("ill_before_ovf", 64'(err_code), 64'd4);

        clear_rom(); rom[0] = ins(3, 0);
        run_prog(-1, MAXC);
        check("pop_empty", 64'(err_code), 64'd2);

        clear_rom(); rom[0] = ins(0, 1); rom[1] = ins(4, 0);
        run_prog(-1, MAXC);
        check("binop_sp1", 64'(err_code), 64'd2);

        clear_rom();
        run_prog(-1, MAXC);
        check("ret_empty", 64'(err_code), 64'd2);

        clear_rom(); rom[0] = ins(1, 16);
        run_prog(-1, MAXC);
        check("load_slot16", 64'(err_code), 64'd4);

        clear_rom(); rom[0] = ins(2, 16);
        run_prog(-1, MAXC);
        check("ill_before_unf", 64'(err_code), 64'd4);

        clear_rom(); rom[0] = ins(0, 1); rom[1] = ins(15, 0);
        run_prog(-1, MAXC);
        check("illegal_op", 64'(err_code), 64'd4);

        load_div(100, 3);
        run_prog(-1, 14);
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_div");
        #1 rst_n = 1'b1;
        load_t1();
        run_prog(-1, MAXC);
        check("after_reset_t1", 64'(result), 64'd10);

        for (int p = 0; p < 30; p++) begin
            clear_rom();
            len = $urandom_range(4, 20);
            for (int pc = 0; pc < len; pc++) begin
                rnd = $urandom_range(0, 99);
                tgt = $urandom_range(pc + 1, len);
                if (rnd < 35)      rom[pc] = ins(0, ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 9) - 4);
                else if (rnd < 45) rom[pc] = ins(1, ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 15));
                else if (rnd < 52) rom[pc] = ins(2, ($urandom_range(0, 19) == 0) ? 17 : $urandom_range(0, 15));
                else if (rnd < 57) rom[pc] = ins(3, 0);
                else if (rnd < 82) rom[pc] = ins($urandom_range(4, 11), 0);
                else if (rnd < 87) rom[pc] = ins(12, tgt);
                else if (rnd < 90) rom[pc] = ins(13, tgt);
                else if (rnd < 91) rom[pc] = ins(15, 0);
                else               rom[pc] = ins(14, 0);
            end
            run_prog(-1, MAXC);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
